useq_mailbox: RTL and testbench
===============================

USEQ_MAILBOX -- requirements
Module: useq_mailbox

Interface
REQ-001 SHALL have parameter DATA_W, default 8: word width of both FIFOs.
REQ-002 SHALL have parameter DEPTH, default 4: entries per FIFO; power of two, >= 2.
REQ-003 SHALL have parameter WM, default 1: host-to-core watermark level, 1..DEPTH.
REQ-004 SHALL have port clk  input  1: sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1: synchronous reset, active-high.
REQ-006 SHALL have ports host_wr input 1, host_din input DATA_W, host_full output 1: host writes into the host-to-core (H2C) FIFO.
REQ-007 SHALL have ports core_rd input 1, core_dout output DATA_W, core_empty output 1: core reads the H2C FIFO.
REQ-008 SHALL have ports core_wr input 1, core_din input DATA_W, core_full output 1: core writes into the core-to-host (C2H) FIFO.
REQ-009 SHALL have ports host_rd input 1, host_dout output DATA_W, host_empty output 1: host reads the C2H FIFO.
REQ-010 SHALL have ports h2c_level and c2h_level, output, $clog2(DEPTH+1) bits: current occupancy of each FIFO.
REQ-011 SHALL have ports ovf output 1, unf output 1, err_clr input 1: sticky overflow/underflow flags and their clear.
REQ-012 SHALL have port irq  output 1: core interrupt request.

Function
REQ-013 Each FIFO SHALL be first-word-fall-through: dout shows the head entry whenever not empty; rd pops it at the clock edge.
REQ-014 A write SHALL be accepted at the edge when wr=1 and the FIFO is not full; the data is visible on dout the next cycle if the FIFO was empty.
REQ-015 Write while full with no simultaneous read SHALL be dropped, leave contents unchanged, and set ovf.
REQ-016 Read while empty SHALL be ignored, leave dout unchanged, and set unf.
REQ-017 Simultaneous rd+wr when full SHALL pop the head and push the new word; level is unchanged; ovf is not set.
REQ-018 Simultaneous rd+wr when empty SHALL accept the write, ignore the read, and set unf.
REQ-019 Pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH; the level counter is tracked separately (0..DEPTH).
REQ-020 full = (level == DEPTH) and empty = (level == 0); both SHALL be registered-state-derived, with no combinational path from rd/wr.
REQ-021 ovf and unf SHALL aggregate both FIFOs and stay set until err_clr=1; if err_clr coincides with a new error, the flag stays set.
REQ-022 The H2C and C2H FIFOs SHALL be fully independent; activity on one never alters the other.

Reset
REQ-023 While rst=1 at an edge: both FIFOs empty, pointers 0, levels 0, ovf=0, unf=0, irq=0, and core_dout/host_dout = 0.
REQ-024 Reset mid-transfer SHALL discard all stored words; rd/wr sampled during reset are ignored.
REQ-025 Outputs after reset: core_empty=1, host_empty=1, core_full=0, host_full=0.

Configuration
REQ-026 Macro USEQ_MBOX_WATERMARK_EN defined: irq is a register set when h2c_level >= WM (one cycle after the level is reached) and cleared the cycle after h2c_level < WM.
REQ-027 Macro USEQ_MBOX_WATERMARK_EN undefined: irq SHALL be tied to 0, WM has no effect, and no watermark logic is generated.

Verification (DATA_W=8, DEPTH=4, WM=2, macro defined unless noted)
REQ-028 Reset, then host_wr CC, DD, EE, FF, 11 on consecutive cycles -> after the 4th write host_full=1, h2c_level=4; the 11 write is dropped and ovf=1; core_dout=CC.
REQ-029 From full: core_rd for 4 cycles -> core_dout reads CC, DD, EE, FF, then core_empty=1; a 5th core_rd sets unf=1; err_clr -> ovf=unf=0.
REQ-030 C2H at level 4, then core_wr=1 and host_rd=1 in the same cycle with core_din=5A -> level stays 4, no ovf; after 3 further pops host_dout=5A.
REQ-031 Write 1 then 2 words to H2C -> irq=0 at level 1; irq=1 one cycle after level reaches 2; one core_rd -> irq=0 the next cycle; with the macro undefined, irq stays 0 throughout.
REQ-032 Push 3 words, assert rst for 1 cycle mid-stream -> all levels 0, both empty=1, irq=0, and 10 push/pop cycles afterwards show correct pointer wrap with data intact.

Source files
------------

// File: rtl/useq_mailbox_if.sv
// rtl/useq_mailbox_if.sv - bus bundle for the host/core mailbox
//
// Purpose: groups every mailbox signal except clk/rst.
// Ports (master drives, slave responds):
//   host_wr/host_din -> H2C push, host_full <- H2C full
//   core_rd          -> H2C pop,  core_dout/core_empty <- H2C head/empty
//   core_wr/core_din -> C2H push, core_full <- C2H full
//   host_rd          -> C2H pop,  host_dout/host_empty <- C2H head/empty
//   h2c_level/c2h_level <- occupancies, ovf/unf <- sticky errors
//   err_clr          -> clears ovf/unf, irq <- core interrupt
interface useq_mailbox_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
);
   localparam int LVL_W = $clog2(DEPTH + 1);

   logic              host_wr;
   logic [DATA_W-1:0] host_din;
   logic              host_full;
   logic              core_rd;
   logic [DATA_W-1:0] core_dout;
   logic              core_empty;
   logic              core_wr;
   logic [DATA_W-1:0] core_din;
   logic              core_full;
   logic              host_rd;
   logic [DATA_W-1:0] host_dout;
   logic              host_empty;
   logic [LVL_W-1:0]  h2c_level;
   logic [LVL_W-1:0]  c2h_level;
   logic              ovf;
   logic              unf;
   logic              err_clr;
   logic              irq;

   modport master (
      output host_wr, host_din, core_rd, core_wr, core_din, host_rd, err_clr,
      input  host_full, core_dout, core_empty, core_full, host_dout, host_empty,
             h2c_level, c2h_level, ovf, unf, irq
   );

   modport slave (
      input  host_wr, host_din, core_rd, core_wr, core_din, host_rd, err_clr,
      output host_full, core_dout, core_empty, core_full, host_dout, host_empty,
             h2c_level, c2h_level, ovf, unf, irq
   );
endinterface

// File: rtl/useq_mailbox.sv
// rtl/useq_mailbox.sv - bidirectional host/core mailbox with two FWFT FIFOs
//
// Purpose: host-to-core (H2C) and core-to-host (C2H) FIFOs, sticky
// overflow/underflow flags and an optional H2C watermark interrupt.
// Optional feature macro: USEQ_MBOX_WATERMARK_EN (irq = registered
// h2c_level >= WM); when undefined irq is tied low.
// Ports:
//   clk  - sole clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - useq_mailbox_if.slave (see rtl/useq_mailbox_if.sv)
// Modules:
//   useq_mbox_fifo - one FWFT FIFO with registered head and error pulses
//   useq_mailbox   - top: two FIFOs, sticky flags, irq

module useq_mbox_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   parameter int LVL_W  = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr,
   input  logic [DATA_W-1:0] din,
   input  logic              rd,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty,
   output logic [LVL_W-1:0]  level,
   output logic              ovf_evt,
   output logic              unf_evt
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  rd_ptr_inc;
   logic [LVL_W-1:0]  level_q;
   logic [DATA_W-1:0] dout_q;
   logic              push;
   logic              pop;

   // Flags come only from the level register, never from rd/wr.
   assign full  = (level_q == LVL_W'(DEPTH));
   assign empty = (level_q == '0);

   // A full FIFO still accepts a write when the same edge pops the head.
   assign push    = wr && (!full || rd);
   assign pop     = rd && !empty;
   assign ovf_evt = wr && full && !rd;
   assign unf_evt = rd && empty;

   assign rd_ptr_inc = rd_ptr + PTR_W'(1);

   always_ff @(posedge clk) begin
      if (!rst && push)
         mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
         dout_q  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr_inc;
         if (push && !pop)
            level_q <= level_q + LVL_W'(1);
         else if (pop && !push)
            level_q <= level_q - LVL_W'(1);

         // Registered head: next entry after a pop, or the incoming word
         // when it lands in an otherwise empty FIFO. Otherwise hold, so a
         // read on empty leaves dout as it was.
         if (pop) begin
            if (level_q > LVL_W'(1))
               dout_q <= mem[rd_ptr_inc];
            else if (push)
               dout_q <= din;
         end else if (push && empty) begin
            dout_q <= din;
         end
      end
   end

   assign dout  = dout_q;
   assign level = level_q;
endmodule

module useq_mailbox #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   parameter int WM     = 1
) (
   input  logic           clk,
   input  logic           rst,
   useq_mailbox_if.slave  bus
);
   localparam int LVL_W = $clog2(DEPTH + 1);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || WM < 1 || WM > DEPTH) begin : g_param_chk
      $error("useq_mailbox: bad DEPTH/WM");
   end

   logic h2c_ovf, h2c_unf, c2h_ovf, c2h_unf;
   logic ovf_q, unf_q;

   useq_mbox_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LVL_W(LVL_W)) u_h2c (
      .clk     (clk),
      .rst     (rst),
      .wr      (bus.host_wr),
      .din     (bus.host_din),
      .rd      (bus.core_rd),
      .dout    (bus.core_dout),
      .full    (bus.host_full),
      .empty   (bus.core_empty),
      .level   (bus.h2c_level),
      .ovf_evt (h2c_ovf),
      .unf_evt (h2c_unf)
   );

   useq_mbox_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LVL_W(LVL_W)) u_c2h (
      .clk     (clk),
      .rst     (rst),
      .wr      (bus.core_wr),
      .din     (bus.core_din),
      .rd      (bus.host_rd),
      .dout    (bus.host_dout),
      .full    (bus.core_full),
      .empty   (bus.host_empty),
      .level   (bus.c2h_level),
      .ovf_evt (c2h_ovf),
      .unf_evt (c2h_unf)
   );

   // A new error in the clear cycle wins over the clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= (ovf_q && !bus.err_clr) || h2c_ovf || c2h_ovf;
         unf_q <= (unf_q && !bus.err_clr) || h2c_unf || c2h_unf;
      end
   end

   assign bus.ovf = ovf_q;
   assign bus.unf = unf_q;

`ifdef USEQ_MBOX_WATERMARK_EN
   logic irq_q;

   // Follows the registered level, so irq trails the level by one cycle.
   always_ff @(posedge clk) begin
      if (rst)
         irq_q <= 1'b0;
      else
         irq_q <= (bus.h2c_level >= LVL_W'(WM));
   end

   assign bus.irq = irq_q;
`else
   assign bus.irq = 1'b0;
`endif
endmodule

// File: tb/tb_useq_mailbox.sv
// tb/tb_useq_mailbox.sv - scoreboard bench for useq_mailbox
module tb_useq_mailbox;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 4;
   localparam int WM     = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   useq_mailbox_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

   useq_mailbox #(.DATA_W(DATA_W), .DEPTH(DEPTH), .WM(WM)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [7:0] cdout;
      logic [7:0] hdout;
      logic       ce, cf, he, hf, ovf, unf, irq;
      int         hl, cl;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] h2c[$];
   logic [7:0] c2h[$];
   logic [7:0] last_h2c, last_c2h;
   bit         m_ovf, m_unf, m_irq;
   int         checks = 0;
   int         passes = 0;

   // Reference FIFO: a queue. Pop first, then push if there was room
   // before the edge or a read freed a slot.
   function automatic void step(input int f, input bit wr, input logic [7:0] d,
                                input bit rd, output bit o, output bit u);
      int n;
      n = (f == 0) ? h2c.size() : c2h.size();
      o = wr && (n == DEPTH) && !rd;
      u = rd && (n == 0);
      if (rd && n > 0) begin
         if (f == 0) void'(h2c.pop_front());
         else        void'(c2h.pop_front());
      end
      if (wr && (n < DEPTH || rd)) begin
         if (f == 0) h2c.push_back(d);
         else        c2h.push_back(d);
      end
   endfunction

   task automatic cycle(input bit r, input bit hw, input logic [7:0] hd,
                        input bit cr, input bit cw, input logic [7:0] cd,
                        input bit hr, input bit clr);
      bit   o0, u0, o1, u1;
      exp_t e;
      @(negedge clk);
      rst = r;
      bus.host_wr = hw; bus.host_din = hd; bus.core_rd = cr;
      bus.core_wr = cw; bus.core_din = cd; bus.host_rd = hr;
      bus.err_clr = clr;
      if (r) begin
         h2c.delete(); c2h.delete();
         last_h2c = 8'h00; last_c2h = 8'h00;
         m_ovf = 1'b0; m_unf = 1'b0; m_irq = 1'b0;
      end else begin
`ifdef USEQ_MBOX_WATERMARK_EN
         m_irq = (h2c.size() >= WM);
`else
         m_irq = 1'b0;
`endif
         step(0, hw, hd, cr, o0, u0);
         step(1, cw, cd, hr, o1, u1);
         m_ovf = (m_ovf && !clr) || o0 || o1;
         m_unf = (m_unf && !clr) || u0 || u1;
      end
      if (h2c.size() != 0) last_h2c = h2c[0];
      if (c2h.size() != 0) last_c2h = c2h[0];
      e.cdout = last_h2c;  e.hdout = last_c2h;
      e.ce = (h2c.size() == 0); e.hf = (h2c.size() == DEPTH);
      e.he = (c2h.size() == 0); e.cf = (c2h.size() == DEPTH);
      e.hl = h2c.size(); e.cl = c2h.size();
      e.ovf = m_ovf; e.unf = m_unf; e.irq = m_irq;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req)
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      else
         passes++;
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("core_dout",  32'(bus.core_dout),  32'(e.cdout));
            chk("host_dout",  32'(bus.host_dout),  32'(e.hdout));
            chk("core_empty", 32'(bus.core_empty), 32'(e.ce));
            chk("host_full",  32'(bus.host_full),  32'(e.hf));
            chk("host_empty", 32'(bus.host_empty), 32'(e.he));
            chk("core_full",  32'(bus.core_full),  32'(e.cf));
            chk("h2c_level",  32'(bus.h2c_level),  32'(e.hl));
            chk("c2h_level",  32'(bus.c2h_level),  32'(e.cl));
            chk("ovf",        32'(bus.ovf),        32'(e.ovf));
            chk("unf",        32'(bus.unf),        32'(e.unf));
            chk("irq",        32'(bus.irq),        32'(e.irq));
         end
      end
   end

   initial begin
      logic [7:0] words [5];
      bus.host_wr = 0; bus.host_din = 0; bus.core_rd = 0; bus.core_wr = 0;
      bus.core_din = 0; bus.host_rd = 0; bus.err_clr = 0;
      words[0] = 8'hCC; words[1] = 8'hDD; words[2] = 8'hEE;
      words[3] = 8'hFF; words[4] = 8'h11;

      // reset state
      cycle(1, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 0);

      // fill H2C, fifth write overflows
      for (int i = 0; i < 5; i++) cycle(0, 1, words[i], 0, 0, 0, 0, 0);
      // drain, fifth read underflows, then clear
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 0, 0, 0);

      // C2H full with simultaneous push/pop
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1, 8'(8'h30 + i), 0, 0);
      cycle(0, 0, 0, 0, 1, 8'h5A, 1, 0);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 1, 0);
      cycle(0, 0, 0, 0, 0, 0, 1, 0);

      // err_clr in the same cycle as a new underflow keeps unf set
      cycle(0, 0, 0, 1, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 0, 0, 1);

      // watermark
      cycle(0, 1, 8'h01, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 1, 8'h02, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 0);

      // reset mid-stream, then wrap traffic
      for (int i = 0; i < 3; i++) cycle(0, 1, 8'(8'hA0 + i), 0, 1, 8'(8'hB0 + i), 0, 0);
      cycle(1, 1, 8'h77, 1, 1, 8'h66, 1, 0);
      for (int i = 0; i < 10; i++)
         cycle(0, 1, 8'(8'hC0 + i), i > 1, 1, 8'(8'hD0 + i), i > 2, 0);

      // random traffic with occasional reset and clear
      for (int i = 0; i < 500; i++)
         cycle($urandom_range(0, 59) == 0, 1'($urandom), 8'($urandom),
               1'($urandom), 1'($urandom), 8'($urandom),
               1'($urandom), $urandom_range(0, 9) == 0);

      cycle(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
